// File: rtl/i2s_pkg.sv
// Shared types and helpers for the stereo I2S transmitter.
package i2s_pkg;

  typedef enum logic {
    I2S_PHILIPS = 1'b0,
    I2S_LJ      = 1'b1
  } i2s_mode_e;

  // clk cycles in one stereo frame (two slots of SLOT_W bit clocks each)
  function automatic int unsigned frame_clks(input int unsigned slot_w,
                                             input int unsigned bclk_div);
    return 2 * slot_w * bclk_div;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock and frame timing: divides clk into BCLK periods, counts bit slots
// across a stereo frame and produces registered bclk/lrclk plus frame strobes.
module i2s_bclk_gen #(
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 14,
  localparam int DW      = $clog2(BCLK_DIV),
  localparam int BW      = $clog2(2 * SLOT_W)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [BW-1:0] bit_cnt_nxt,
  output logic          bit_adv,
  output logic          frame_load,
  output logic          frame_start,
  output logic          bclk,
  output logic          lrclk
);

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_W);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic          frame_start_q, frame_start_d;

  // bit_adv marks the last clk of a BCLK period; the next clk is the falling edge
  always_comb begin
    bit_adv       = (div_cnt_q == DIV_LAST);
    bit_cnt_nxt   = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
    frame_load    = bit_adv && (bit_cnt_q == BIT_LAST);
    div_cnt_d     = bit_adv ? '0 : div_cnt_q + DW'(1);
    bit_cnt_d     = bit_adv ? bit_cnt_nxt : bit_cnt_q;
    bclk_d        = (div_cnt_d >= DIV_HALF);
    lrclk_d       = (bit_cnt_d >= SLOT_LEN);
    frame_start_d = frame_load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign frame_start = frame_start_q;

endmodule

// File: rtl/i2s_stereo_tx.sv
// Stereo I2S / left-justified transmitter: one-entry sample buffer, per-frame
// sample latch with mute and underrun handling, and registered serial data.
module i2s_stereo_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [SAMPLE_W-1:0] sample_left,
  input  logic [SAMPLE_W-1:0] sample_right,
  input  logic                mode,
  input  logic                mute,
  output logic                i2s_audio_en,
  output logic                i2s_audio_din,
  output logic                i2s_audio_lrclk,
  output logic                i2s_audio_bclk,
  output logic                frame_start,
  output logic                underrun
);

  localparam int BW = $clog2(2 * SLOT_W);
  localparam logic [BW-1:0]       SLOT_LEN = BW'(SLOT_W);
  localparam logic [BW-1:0]       DATA_LEN = BW'(SAMPLE_W);
  localparam logic [SAMPLE_W-1:0] MSB_ONE  = {1'b1, {(SAMPLE_W-1){1'b0}}};

  if (SLOT_W < SAMPLE_W + 1) begin : g_bad_slot
    $error("i2s_stereo_tx: SLOT_W must be at least SAMPLE_W+1");
  end
  if ((BCLK_DIV < 2) || (BCLK_DIV % 2 != 0)) begin : g_bad_div
    $error("i2s_stereo_tx: BCLK_DIV must be even and at least 2");
  end

  logic [BW-1:0] bit_cnt_nxt;
  logic          bit_adv;
  logic          frame_load;

  i2s_bclk_gen #(
    .SLOT_W   (SLOT_W),
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk         (clk),
    .reset       (reset),
    .bit_cnt_nxt (bit_cnt_nxt),
    .bit_adv     (bit_adv),
    .frame_load  (frame_load),
    .frame_start (frame_start),
    .bclk        (i2s_audio_bclk),
    .lrclk       (i2s_audio_lrclk)
  );

  logic                buf_full_q, buf_full_d;
  logic [SAMPLE_W-1:0] buf_left_q, buf_left_d;
  logic [SAMPLE_W-1:0] buf_right_q, buf_right_d;
  logic [SAMPLE_W-1:0] tx_left_q, tx_left_d;
  logic [SAMPLE_W-1:0] tx_right_q, tx_right_d;
  i2s_mode_e           mode_q, mode_d;
  logic                din_q, din_d;
  logic                underrun_q, underrun_d;
  logic                en_q, en_d;
  logic                sample_accept;

  // Handshake: a pair transfers on any clk with sample_valid && sample_ready;
  // sample_ready is simply "buffer empty", so valid while not ready is ignored
  // and the source need not hold data. A load on the accept clk still sees empty.
  always_comb begin
    sample_accept = sample_valid && !buf_full_q;
    buf_full_d    = buf_full_q;
    buf_left_d    = buf_left_q;
    buf_right_d   = buf_right_q;
    tx_left_d     = tx_left_q;
    tx_right_d    = tx_right_q;
    mode_d        = mode_q;
    underrun_d    = 1'b0;
    en_d          = en_q | frame_load;
    if (frame_load) begin
      mode_d = i2s_mode_e'(mode);
      if (mute) begin
        tx_left_d  = '0;
        tx_right_d = '0;
      end else if (buf_full_q) begin
        tx_left_d  = buf_left_q;
        tx_right_d = buf_right_q;
        buf_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end
    if (sample_accept) begin
      buf_full_d  = 1'b1;
      buf_left_d  = sample_left;
      buf_right_d = sample_right;
    end
  end

  logic [BW-1:0]       slot_pos;
  logic [BW-1:0]       data_pos;
  logic [SAMPLE_W-1:0] word;
  logic                in_data;
  logic                serial_bit;

  // din is computed for the upcoming bit slot so it changes on the BCLK fall
  always_comb begin
    slot_pos = bit_cnt_nxt;
    word     = tx_left_d;
    if (bit_cnt_nxt >= SLOT_LEN) begin
      slot_pos = bit_cnt_nxt - SLOT_LEN;
      word     = tx_right_d;
    end
    data_pos   = (mode_d == I2S_LJ) ? slot_pos : slot_pos - BW'(1);
    in_data    = ((mode_d == I2S_LJ) || (slot_pos != '0)) && (data_pos < DATA_LEN);
    serial_bit = in_data && |(word & (MSB_ONE >> data_pos));
    din_d      = bit_adv ? serial_bit : din_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full_q  <= 1'b0;
      buf_left_q  <= '0;
      buf_right_q <= '0;
      tx_left_q   <= '0;
      tx_right_q  <= '0;
      mode_q      <= I2S_PHILIPS;
      din_q       <= 1'b0;
      underrun_q  <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      buf_full_q  <= buf_full_d;
      buf_left_q  <= buf_left_d;
      buf_right_q <= buf_right_d;
      tx_left_q   <= tx_left_d;
      tx_right_q  <= tx_right_d;
      mode_q      <= mode_d;
      din_q       <= din_d;
      underrun_q  <= underrun_d;
      en_q        <= en_d;
    end
  end

  assign sample_ready  = !buf_full_q;
  assign i2s_audio_din = din_q;
  assign i2s_audio_en  = en_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Self-checking bench for i2s_stereo_tx with a frame-level reference model.
module tb_i2s_stereo_tx;
  import i2s_pkg::*;

  localparam int SW    = 16;
  localparam int SL    = 32;
  localparam int BD    = 14;
  localparam int FRAME = int'(frame_clks(SL, BD));

  logic clk = 1'b0;
  logic reset, sample_valid, mode, mute;
  logic [SW-1:0] sample_left, sample_right;
  logic sample_ready, i2s_audio_en, i2s_audio_din, i2s_audio_lrclk, i2s_audio_bclk;
  logic frame_start, underrun;

  i2s_stereo_tx #(.SAMPLE_W(SW), .SLOT_W(SL), .BCLK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_left(sample_left), .sample_right(sample_right), .mode(mode), .mute(mute),
    .i2s_audio_en(i2s_audio_en), .i2s_audio_din(i2s_audio_din),
    .i2s_audio_lrclk(i2s_audio_lrclk), .i2s_audio_bclk(i2s_audio_bclk),
    .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  // reference model: k = clk edges since reset release; exp_q is the holding buffer
  int k = 0;
  logic [2*SW-1:0] exp_q[$];
  logic [SW-1:0] m_txl = '0, m_txr = '0;
  bit m_lj = 1'b0, e_fs = 1'b0, e_ur = 1'b0, e_en = 1'b0;

  task automatic tick();
    bit load, was_full;
    @(posedge clk);
    if (reset) begin
      k = 0; exp_q.delete(); m_txl = '0; m_txr = '0;
      m_lj = 1'b0; e_fs = 1'b0; e_ur = 1'b0; e_en = 1'b0;
    end else begin
      was_full = (exp_q.size() != 0);
      load     = (k % FRAME) == FRAME - 1;
      e_fs     = load;
      e_ur     = 1'b0;
      if (load) begin
        e_en = 1'b1;
        m_lj = mode;
        if (mute) begin m_txl = '0; m_txr = '0; end
        else if (was_full) {m_txl, m_txr} = exp_q.pop_front();
        else e_ur = 1'b1;
      end
      if (sample_valid && !was_full) exp_q.push_back({sample_left, sample_right});
      k++;
    end
    @(negedge clk);
  endtask

  function automatic logic exp_bclk();
    return (k % BD) >= BD / 2;
  endfunction

  function automatic logic exp_lr();
    return ((k / BD) % (2 * SL)) >= SL;
  endfunction

  function automatic logic exp_din();
    int b, s, p;
    logic [SW-1:0] w;
    b = (k / BD) % (2 * SL);
    s = b % SL;
    w = (b >= SL) ? m_txr : m_txl;
    p = m_lj ? s : s - 1;
    if (p >= 0 && p < SW) return w[SW-1-p];
    return 1'b0;
  endfunction

  task automatic send_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
    sample_valid = 1'b1; sample_left = l; sample_right = r;
    tick();
    sample_valid = 1'b0;
  endtask

  // drive: 0 idle, 1 hold valid with fresh data each clk, 2 random valid/data/mode
  task automatic capture_frame(input int drive, input int mute_bit,
                               output logic [2*SL-1:0] v, output int bad, output int first_bad,
                               output int n_acc, output int n_ur, output int n_fs, output int n_busy);
    int b;
    v = '0; bad = 0; first_bad = -1; n_acc = 0; n_ur = 0; n_fs = 0; n_busy = 0;
    for (int i = 0; i < FRAME && (k % FRAME) != 0; i++) tick();
    for (int i = 0; i < FRAME; i++) begin
      b = (k / BD) % (2 * SL);
      if (drive == 1) begin
        sample_valid = 1'b1; sample_left = SW'($urandom); sample_right = SW'($urandom);
      end else if (drive == 2) begin
        sample_valid = 1'($urandom_range(0, 1)); sample_left = SW'($urandom);
        sample_right = SW'($urandom); mode = 1'($urandom_range(0, 1));
      end
      if (mute_bit >= 0 && (k % BD) == 0 && b == mute_bit) mute = 1'b1;
      if (i2s_audio_bclk !== exp_bclk() || i2s_audio_lrclk !== exp_lr() ||
          i2s_audio_din !== exp_din() || frame_start !== e_fs || underrun !== e_ur ||
          i2s_audio_en !== e_en || sample_ready !== 1'(exp_q.size() == 0)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (sample_valid && sample_ready) n_acc++;
      if (underrun === 1'b1) n_ur++;
      if (frame_start === 1'b1) n_fs++;
      if (sample_ready !== 1'b1) n_busy++;
      if ((k % BD) == BD / 2) v[2*SL-1-b] = i2s_audio_din;
      tick();
    end
    if (drive != 0) sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    int first_fs, first_en, first_ur, din_ones, clk_bad;
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (i2s_audio_bclk !== 1'b0) begin errs++; $display("FAIL reset_bclk got=%b exp=0", i2s_audio_bclk); end
    checks++; if (i2s_audio_lrclk !== 1'b0) begin errs++; $display("FAIL reset_lrclk got=%b exp=0", i2s_audio_lrclk); end
    checks++; if (i2s_audio_din !== 1'b0) begin errs++; $display("FAIL reset_din got=%b exp=0", i2s_audio_din); end
    checks++; if (i2s_audio_en !== 1'b0) begin errs++; $display("FAIL reset_en got=%b exp=0", i2s_audio_en); end
    checks++; if (sample_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b exp=1", sample_ready); end
    checks++; if (frame_start !== 1'b0) begin errs++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
    checks++; if (underrun !== 1'b0) begin errs++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    reset = 1'b0;
    first_fs = -1; first_en = -1; first_ur = -1; din_ones = 0; clk_bad = 0;
    for (int i = 0; i < FRAME + 8; i++) begin
      tick();
      if (frame_start === 1'b1 && first_fs < 0) first_fs = k;
      if (i2s_audio_en === 1'b1 && first_en < 0) first_en = k;
      if (underrun === 1'b1 && first_ur < 0) first_ur = k;
      if (i2s_audio_din !== 1'b0) din_ones++;
      if (i2s_audio_bclk !== exp_bclk() || i2s_audio_lrclk !== exp_lr()) clk_bad++;
    end
    checks++; if (first_fs != FRAME) begin errs++; $display("FAIL first_frame_start got=%0d exp=%0d", first_fs, FRAME); end
    checks++; if (first_en != FRAME) begin errs++; $display("FAIL first_en got=%0d exp=%0d", first_en, FRAME); end
    checks++; if (first_ur != FRAME) begin errs++; $display("FAIL first_underrun got=%0d exp=%0d", first_ur, FRAME); end
    checks++; if (din_ones != 0) begin errs++; $display("FAIL idle_din got=%0d ones exp=0", din_ones); end
    checks++; if (clk_bad != 0) begin errs++; $display("FAIL bclk_lrclk_timing got=%0d bad clks exp=0", clk_bad); end
  endtask

  task automatic test_lj();
    logic [2*SL-1:0] v;
    int bad, fb, na, nu, nf, nb;
    mode = 1'b1;
    send_pair(16'h8000, 16'hFF00);
    capture_frame(0, -1, v, bad, fb, na, nu, nf, nb);
    checks++; if (v !== 64'h80000000_FF000000) begin errs++; $display("FAIL lj_frame got=%h exp=%h", v, 64'h80000000_FF000000); end
    checks++; if (bad != 0) begin errs++; $display("FAIL lj_model got=%0d bad clks (first k=%0d) exp=0", bad, fb); end
  endtask

  task automatic test_i2s();
    logic [2*SL-1:0] v;
    int bad, fb, na, nu, nf, nb;
    mode = 1'b0;
    send_pair(16'h5555, 16'hCC33);
    capture_frame(0, -1, v, bad, fb, na, nu, nf, nb);
    checks++; if (v !== 64'h2AAA8000_66198000) begin errs++; $display("FAIL i2s_frame got=%h exp=%h", v, 64'h2AAA8000_66198000); end
    checks++; if (bad != 0) begin errs++; $display("FAIL i2s_model got=%0d bad clks (first k=%0d) exp=0", bad, fb); end
  endtask

  task automatic test_underrun();
    logic [2*SL-1:0] v0, v, ref_v;
    int bad, fb, na, nu, nf, nb;
    mode = 1'b0;
    ref_v = {1'b0, 16'h1234, 15'd0, 1'b0, 16'hABCD, 15'd0};
    send_pair(16'h1234, 16'hABCD);
    capture_frame(0, -1, v0, bad, fb, na, nu, nf, nb);
    checks++; if (v0 !== ref_v) begin errs++; $display("FAIL underrun_first got=%h exp=%h", v0, ref_v); end
    checks++; if (nu != 0) begin errs++; $display("FAIL underrun_loaded_frame got=%0d pulses exp=0", nu); end
    for (int f = 0; f < 3; f++) begin
      capture_frame(0, -1, v, bad, fb, na, nu, nf, nb);
      checks++; if (v !== ref_v) begin errs++; $display("FAIL underrun_repeat%0d got=%h exp=%h", f, v, ref_v); end
      checks++; if (nu != 1) begin errs++; $display("FAIL underrun_pulses%0d got=%0d exp=1", f, nu); end
      checks++; if (nb != 0) begin errs++; $display("FAIL underrun_ready%0d got=%0d busy clks exp=0", f, nb); end
      checks++; if (bad != 0) begin errs++; $display("FAIL underrun_model%0d got=%0d bad clks (first k=%0d) exp=0", f, bad, fb); end
    end
  endtask

  task automatic test_handshake();
    logic [2*SL-1:0] v, vb, ref_v;
    logic [SW-1:0] pl, pr;
    int bad, fb, na, nu, nf, nb;
    mode = 1'b1;
    for (int f = 0; f < 3; f++) begin
      capture_frame(1, -1, v, bad, fb, na, nu, nf, nb);
      checks++; if (na != 1) begin errs++; $display("FAIL hs_accepts%0d got=%0d exp=1", f, na); end
      checks++; if (bad != 0) begin errs++; $display("FAIL hs_model%0d got=%0d bad clks (first k=%0d) exp=0", f, bad, fb); end
    end
    capture_frame(0, -1, vb, bad, fb, na, nu, nf, nb);
    checks++; if (bad != 0) begin errs++; $display("FAIL hs_last_model got=%0d bad clks exp=0", bad); end
    for (int i = 0; i < FRAME && (k % FRAME) != FRAME - 1; i++) tick();
    pl = SW'($urandom); pr = SW'($urandom);
    send_pair(pl, pr);
    checks++; if (underrun !== 1'b1) begin errs++; $display("FAIL hs_load_accept_underrun got=%b exp=1", underrun); end
    checks++; if (sample_ready !== 1'b0) begin errs++; $display("FAIL hs_load_accept_ready got=%b exp=0", sample_ready); end
    capture_frame(0, -1, v, bad, fb, na, nu, nf, nb);
    checks++; if (v !== vb) begin errs++; $display("FAIL hs_load_accept_reload got=%h exp=%h", v, vb); end
    ref_v = {pl, 16'd0, pr, 16'd0};
    capture_frame(0, -1, v, bad, fb, na, nu, nf, nb);
    checks++; if (v !== ref_v) begin errs++; $display("FAIL hs_load_accept_next got=%h exp=%h", v, ref_v); end
    checks++; if (bad != 0) begin errs++; $display("FAIL hs_tail_model got=%0d bad clks exp=0", bad); end
  endtask

  task automatic test_mute();
    logic [2*SL-1:0] v, ref_v;
    logic [SW-1:0] al, ar;
    int bad, fb, na, nu, nf, nb;
    mode = 1'b1;
    al = SW'($urandom); ar = SW'($urandom);
    ref_v = {al, 16'd0, ar, 16'd0};
    send_pair(al, ar);
    capture_frame(0, 10, v, bad, fb, na, nu, nf, nb);
    checks++; if (v !== ref_v) begin errs++; $display("FAIL mute_midframe got=%h exp=%h", v, ref_v); end
    capture_frame(0, -1, v, bad, fb, na, nu, nf, nb);
    checks++; if (v !== '0) begin errs++; $display("FAIL mute_next_frame got=%h exp=0", v); end
    checks++; if (bad != 0) begin errs++; $display("FAIL mute_model got=%0d bad clks (first k=%0d) exp=0", bad, fb); end
    mute = 1'b0;
  endtask

  task automatic test_random();
    logic [2*SL-1:0] v;
    int bad, fb, na, nu, nf, nb;
    for (int f = 0; f < 4; f++) begin
      capture_frame(2, -1, v, bad, fb, na, nu, nf, nb);
      checks++; if (bad != 0) begin errs++; $display("FAIL random_model%0d got=%0d bad clks (first k=%0d) exp=0", f, bad, fb); end
    end
  endtask

  task automatic test_reset_mid();
    logic [2*SL-1:0] v;
    int bad, fb, na, nu, nf, nb;
    mute = 1'b0;
    send_pair(SW'($urandom), SW'($urandom));
    for (int i = 0; i < FRAME && !((k % BD) == 0 && ((k / BD) % (2 * SL)) == 20); i++) tick();
    reset = 1'b1;
    tick();
    checks++; if (i2s_audio_bclk !== 1'b0) begin errs++; $display("FAIL midreset_bclk got=%b exp=0", i2s_audio_bclk); end
    checks++; if (i2s_audio_lrclk !== 1'b0) begin errs++; $display("FAIL midreset_lrclk got=%b exp=0", i2s_audio_lrclk); end
    checks++; if (i2s_audio_din !== 1'b0) begin errs++; $display("FAIL midreset_din got=%b exp=0", i2s_audio_din); end
    checks++; if (i2s_audio_en !== 1'b0) begin errs++; $display("FAIL midreset_en got=%b exp=0", i2s_audio_en); end
    checks++; if (sample_ready !== 1'b1) begin errs++; $display("FAIL midreset_ready got=%b exp=1", sample_ready); end
    checks++; if (frame_start !== 1'b0) begin errs++; $display("FAIL midreset_frame_start got=%b exp=0", frame_start); end
    checks++; if (underrun !== 1'b0) begin errs++; $display("FAIL midreset_underrun got=%b exp=0", underrun); end
    repeat (2) tick();
    reset = 1'b0;
    capture_frame(0, -1, v, bad, fb, na, nu, nf, nb);
    checks++; if (nf != 0 || nu != 0 || v !== '0) begin errs++; $display("FAIL restart_frame0 got fs=%0d ur=%0d v=%h exp 0/0/0", nf, nu, v); end
    checks++; if (bad != 0) begin errs++; $display("FAIL restart_model0 got=%0d bad clks (first k=%0d) exp=0", bad, fb); end
    capture_frame(0, -1, v, bad, fb, na, nu, nf, nb);
    checks++; if (nf != 1 || nu != 1 || v !== '0) begin errs++; $display("FAIL restart_frame1 got fs=%0d ur=%0d v=%h exp 1/1/0", nf, nu, v); end
    checks++; if (bad != 0) begin errs++; $display("FAIL restart_model1 got=%0d bad clks (first k=%0d) exp=0", bad, fb); end
  endtask

  initial begin
    reset = 1'b1; sample_valid = 1'b0; sample_left = '0; sample_right = '0;
    mode = 1'b0; mute = 1'b0;
    test_reset();
    test_lj();
    test_i2s();
    test_underrun();
    test_handshake();
    test_mute();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/i2s_stereo_tx.md
# i2s_stereo_tx

Parametrised stereo I2S transmitter, successor to the mono `i2s_audio` output stage. It accepts left/right PCM sample pairs through a valid/ready handshake into a one-entry holding buffer and serialises them at a frame rate derived from the system clock (42.95454 MHz). It drives the external DAC pins and supports two modes: Philips I2S and left-justified. It sits between the audio mixer and the board-level I2S pins.

## Interface
- `SAMPLE_W`, 16: sample width in bits, two's complement.
- `SLOT_W`, 32: BCLK periods per channel slot. Must satisfy `SLOT_W >= SAMPLE_W+1`, checked at elaboration.
- `BCLK_DIV`, 14: clk cycles per BCLK period. Must be even and `>= 2`. Defaults give 3.068 MHz BCLK and a 47.94 kHz frame rate (896 clk per frame).

- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `sample_valid` input 1: sample pair offered.
- `sample_ready` output 1: holding buffer empty.
- `sample_left` input SAMPLE_W: left PCM sample.
- `sample_right` input SAMPLE_W: right PCM sample.
- `mode` input 1: 0 = Philips I2S, 1 = left-justified. Sampled only at a frame load.
- `mute` input 1: transmit zeros. Sampled only at a frame load.
- `i2s_audio_en` output 1: DAC enable.
- `i2s_audio_din` output 1: serial data, MSB first.
- `i2s_audio_lrclk` output 1: 0 = left slot, 1 = right slot.
- `i2s_audio_bclk` output 1: bit clock.
- `frame_start` output 1: one-clk pulse on the first clk of each frame.
- `underrun` output 1: one-clk pulse when a frame loads with the buffer empty.

## Operation
- `div_cnt` counts 0..BCLK_DIV-1. `bclk` is 0 while `div_cnt < BCLK_DIV/2`, otherwise 1.
- `bit_cnt` counts 0..2*SLOT_W-1 and advances when `div_cnt` wraps.
- `din` and `lrclk` change only on the clk where `div_cnt` = 0, which is the BCLK falling edge. They are stable across the rising edge.
- `lrclk` = (`bit_cnt >= SLOT_W`) in both modes.
- Slot position: p = `bit_cnt mod SLOT_W` in left-justified mode, p = (`bit_cnt mod SLOT_W`) − 1 in I2S mode.
- `din` = `shift[SAMPLE_W-1-p]` when 0 ≤ p < SAMPLE_W, else 0. In I2S mode the slot's first bit is therefore 0.
- Frame load occurs on the clk where `div_cnt` = BCLK_DIV−1 and `bit_cnt` = 2*SLOT_W−1. At that clk, `mode` and `mute` are latched and the shift registers are loaded:
  - mute = 1: both channels load 0.
  - buffer full: both channels load the buffer contents, and the buffer is emptied.
  - buffer empty: both channels reload the previously transmitted samples, and `underrun` pulses. After reset the previous samples are 0.
- Handshake: a pair is accepted when `sample_valid & sample_ready`, and the buffer is written on that clk. `sample_ready` = buffer empty, driven registered.
- Valid while ready = 0: ignored. Data is not required to hold.
- Accept on the same clk as a frame load with the buffer empty: the load still sees "empty", so it reloads the previous samples and pulses `underrun`. The new pair lands in the buffer and goes out at the next frame.
- `i2s_audio_en`: 0 from reset, set at the first `frame_start`, held until reset.

## Timing
- Reset values: `bclk`=0, `lrclk`=0, `din`=0, `en`=0, `sample_ready`=1, `frame_start`=0, `underrun`=0. Counters, buffer and previous-sample registers are all cleared.
- First `frame_start` occurs at clk 896 after reset deasserts, with default parameters.
- Latency: an accepted pair appears starting at the next frame boundary. The left MSB is on `din` at `bit_cnt` 0 (LJ) or 1 (I2S).
- `sample_ready` rises on the clk after a frame load that emptied the buffer.
- Reset mid-frame: all outputs return to reset values on the next clk and the frame is abandoned. There is no partial-frame completion.
- `mode` and `mute` changes mid-frame have no effect until the next load.

## Structure
- Package `i2s_pkg`:
  - mode enum `I2S_PHILIPS`=0, `I2S_LJ`=1.
  - helper function for frame length (`2*SLOT_W*BCLK_DIV`).
- Sub-module `i2s_bclk_gen`: `div_cnt`/`bit_cnt`, `bclk`, `lrclk`, and the `frame_load`/`frame_start` strobes.
- Top: holding buffer, shift registers, mute/underrun logic.

## Test plan
- Reset: hold `reset` 3 clk, then release with no samples → all outputs at reset values. `underrun` pulses at the first frame load; `frame_start` and `en`=1 appear at clk 896. `din` stays 0.
- LJ mode: `mode`=1, send L=16'h8000, R=16'hFF00 → left slot serialises 1 then 31 zeros. Right slot serialises 8 ones, then 24 zeros. `lrclk` high for BCLK 32..63.
- I2S mode: `mode`=0, send L=16'h5555, R=16'hCC33 → `din`=0 at bit 0. Left bits 1..16 = 0101…01, right bits 33..48 = 1100110000110011. `lrclk` toggles one BCLK before each MSB.
- Underrun: send one pair (16'h1234/16'hABCD), then nothing for 3 frames → the same pair repeats each frame and `underrun` pulses once per frame. `sample_ready` stays 1.
- Handshake: hold `sample_valid` with 3 different pairs → exactly one pair is accepted per frame. Pairs offered while `sample_ready`=0 are not transmitted. An accept coinciding with the load clk is transmitted one frame later.
- Mute and reset: set `mute`=1 mid-frame → zeros from the next frame only. Assert `reset` at `bit_cnt`=20 → all outputs return to reset values on the next clk, and the restart timing is identical to the reset case.
